pipe_ripple_adder: RTL

//  Parametrised, pipelined ripple-carry adder built from full-adder cells. Splits WIDTH-bit operands

---
 rtl/pipe_ripple_adder_pkg.sv | 19 +
 rtl/pipe_ripple_adder_if.sv | 36 +++
 rtl/pipe_ripple_adder_fa_chunk.sv | 25 ++
 rtl/pipe_ripple_adder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/pipe_ripple_adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: chunk sizing, configuration check and the
// per-stage control payload.
package pipe_adder_pkg;

    function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Control travelling with each beat; data bits (finished sums, skewed operands) sit beside it.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

endpackage

// File: rtl/pipe_ripple_adder_if.sv
// Valid/ready operand and result streams of pipe_ripple_adder.
// in_sub exists only when PIPE_ADDER_SUB_EN is defined.
interface pipe_ripple_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef PIPE_ADDER_SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
`ifdef PIPE_ADDER_SUB_EN
        output in_sub,
`endif
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
`ifdef PIPE_ADDER_SUB_EN
        input  in_sub,
`endif
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

endinterface

// File: rtl/pipe_ripple_adder_fa_chunk.sv
// Combinational ripple of CHUNK full-adder cells.
module fa_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);
    logic [CHUNK:0] w_c;

    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < CHUNK; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/pipe_ripple_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES chunks, carry registered between
// stages, one global advance enable. Define PIPE_ADDER_SUB_EN to enable the in_sub (A-B) mode.
module pipe_ripple_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input logic                clk,
    input logic                rst,
    pipe_ripple_adder_if.slave io_bus
);
    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $fatal(1, "pipe_ripple_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

`ifdef PIPE_ADDER_SUB_EN
    // A - B as A + ~B + 1; inverting at entry means the sub flag needs no further stages.
    assign w_b_eff   = io_bus.in_b ^ {WIDTH{io_bus.in_sub}};
    assign w_cin_eff = io_bus.in_sub | io_bus.in_cin;
`else
    assign w_b_eff   = io_bus.in_b;
    assign w_cin_eff = io_bus.in_cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Register layout: {b_hi, a_hi, sum_lo}; sum_lo grows by a chunk per stage.
        localparam int unsigned SumW = (k + 1) * CHUNK;
        localparam int unsigned OpW  = WIDTH - SumW;
        localparam int unsigned DW   = SumW + 2 * OpW;

        logic [CHUNK-1:0] w_a;
        logic [CHUNK-1:0] w_b;
        logic [CHUNK-1:0] w_s;
        logic             w_ci;
        logic             w_co;
        logic             w_vi;
        logic [DW-1:0]    w_d;
        stage_ctrl_t      w_ctrl;
        logic [DW-1:0]    r_d;
        stage_ctrl_t      r_ctrl;

        if (k == 0) begin : g_first
            assign w_a  = io_bus.in_a[CHUNK-1:0];
            assign w_b  = w_b_eff[CHUNK-1:0];
            assign w_ci = w_cin_eff;
            assign w_vi = io_bus.in_valid;
            if (OpW > 0) begin : g_hi
                assign w_d = {w_b_eff[WIDTH-1:CHUNK], io_bus.in_a[WIDTH-1:CHUNK], w_s};
            end else begin : g_nohi
                assign w_d = w_s;
            end
        end else begin : g_next
            localparam int unsigned PSumW = k * CHUNK;
            localparam int unsigned POpW  = WIDTH - PSumW;

            assign w_a  = g_stage[k-1].r_d[PSumW +: CHUNK];
            assign w_b  = g_stage[k-1].r_d[PSumW + POpW +: CHUNK];
            assign w_ci = g_stage[k-1].r_ctrl.carry;
            assign w_vi = g_stage[k-1].r_ctrl.valid;
            if (OpW > 0) begin : g_hi
                assign w_d = {g_stage[k-1].r_d[PSumW + POpW + CHUNK +: OpW],
                              g_stage[k-1].r_d[PSumW + CHUNK +: OpW],
                              w_s,
                              g_stage[k-1].r_d[PSumW-1:0]};
            end else begin : g_nohi
                assign w_d = {w_s, g_stage[k-1].r_d[PSumW-1:0]};
            end
        end

        fa_chunk #(
            .CHUNK (CHUNK)
        ) u_fa (
            .i_a    (w_a),
            .i_b    (w_b),
            .i_cin  (w_ci),
            .o_sum  (w_s),
            .o_cout (w_co)
        );

        assign w_ctrl = '{valid: w_vi, carry: w_co};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ctrl <= '0;
                r_d    <= '0;
            end else if (w_adv) begin
                r_ctrl <= w_ctrl;
                r_d    <= w_d;
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic r_ovf;

            // Carry into the MSB is recovered from its cell as a ^ b ^ s.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_co ^ w_a[CHUNK-1] ^ w_b[CHUNK-1] ^ w_s[CHUNK-1];
                end
            end
        end
    end

    assign w_adv            = !g_stage[STAGES-1].r_ctrl.valid || io_bus.out_ready;
    assign io_bus.in_ready  = w_adv;
    assign io_bus.out_valid = g_stage[STAGES-1].r_ctrl.valid;
    assign io_bus.out_cout  = g_stage[STAGES-1].r_ctrl.carry;
    assign io_bus.out_sum   = g_stage[STAGES-1].r_d;
    assign io_bus.out_ovf   = g_stage[STAGES-1].g_last.r_ovf;

endmodule
